// File: rtl/frame_update_scheduler.sv
// Per-frame update sequencer: frame event from VGA row 511, per-client dividers, serial req/done slots.
// Optional watchdog on the WAIT state is enabled by defining SCHED_TIMEOUT_EN.
`timescale 1ns/1ps
module frame_update_scheduler #(
    parameter int NUM_CLIENTS = 4,
    parameter int DIV_W       = 4,
    parameter int TIMEOUT     = 1023
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [8:0]                   row_addr,
    input  logic                         pause,
    input  logic                         clr_flags,
    input  logic [NUM_CLIENTS*DIV_W-1:0] div_cfg,
    input  logic [NUM_CLIENTS-1:0]       upd_done,
    output logic [NUM_CLIENTS-1:0]       upd_req,
    output logic                         frame_tick,
    output logic                         busy,
    output logic                         overrun,
    output logic                         err_timeout
);
    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLIENTS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, WAIT} state_t;

    state_t                             state, state_n;
    logic [IDX_W-1:0]                   idx, idx_n;
    logic [NUM_CLIENTS-1:0]             due, due_n, due_calc;
    logic [NUM_CLIENTS-1:0]             req_n;
    logic [NUM_CLIENTS-1:0][DIV_W-1:0]  cnt, cnt_n, cnt_adv;
    logic [8:0]                         prev_row;
    logic                               frame_evt, accept, advance;
    logic                               pending, pending_n, overrun_n;

    assign frame_evt = (row_addr == 9'd511) && (prev_row != 9'd511);
    assign accept    = frame_evt && !pause;
    assign busy      = (state != IDLE);

    // >= rather than == lets a divisor lowered mid-run fire once and resync
    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_div
        logic [DIV_W-1:0] d;
        assign d           = div_cfg[i*DIV_W +: DIV_W];
        assign due_calc[i] = (d != '0) && (cnt[i] >= d - DIV_W'(1));
        assign cnt_adv[i]  = ((d == '0) || due_calc[i]) ? '0 : cnt[i] + DIV_W'(1);
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [WCNT_W-1:0] wcnt, wcnt_n;
    logic              expire, timeout_n;
    assign expire = (wcnt == WCNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign err_timeout    = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        due_n     = due;
        cnt_n     = cnt;
        req_n     = upd_req;
        pending_n = pending;
        advance   = 1'b0;
        overrun_n = clr_flags ? 1'b0 : overrun;
`ifdef SCHED_TIMEOUT_EN
        wcnt_n    = wcnt;
        timeout_n = clr_flags ? 1'b0 : err_timeout;
`endif
        unique case (state)
            IDLE: begin
                if (pending || accept) begin
                    due_n     = due_calc;
                    cnt_n     = cnt_adv;
                    idx_n     = '0;
                    state_n   = SCAN;
                    // a raw event on the edge that consumes the deferred frame becomes the new pending one
                    pending_n = pending && accept;
                end
            end
            SCAN: begin
                if (due[idx]) begin
                    req_n      = '0;
                    req_n[idx] = 1'b1;
                    state_n    = WAIT;
`ifdef SCHED_TIMEOUT_EN
                    wcnt_n     = '0;
`endif
                end else begin
                    advance = 1'b1;
                end
            end
            WAIT: begin
                if (upd_done[idx]) begin
                    req_n   = '0;
                    advance = 1'b1;
`ifdef SCHED_TIMEOUT_EN
                end else if (expire) begin
                    req_n     = '0;
                    timeout_n = 1'b1;
                    advance   = 1'b1;
                end else begin
                    wcnt_n = wcnt + WCNT_W'(1);
`endif
                end
            end
            default: state_n = IDLE;
        endcase

        if (advance) begin
            if (idx == LAST_IDX) begin
                state_n = IDLE;
                idx_n   = '0;
            end else begin
                state_n = SCAN;
                idx_n   = idx + IDX_W'(1);
            end
        end

        if ((state != IDLE) && accept) begin
            if (pending) overrun_n = 1'b1;
            else         pending_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            due        <= '0;
            cnt        <= '0;
            upd_req    <= '0;
            pending    <= 1'b0;
            overrun    <= 1'b0;
            frame_tick <= 1'b0;
            prev_row   <= 9'd511;
`ifdef SCHED_TIMEOUT_EN
            wcnt        <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            due        <= due_n;
            cnt        <= cnt_n;
            upd_req    <= req_n;
            pending    <= pending_n;
            overrun    <= overrun_n;
            frame_tick <= frame_evt;
            prev_row   <= row_addr;
`ifdef SCHED_TIMEOUT_EN
            wcnt        <= wcnt_n;
            err_timeout <= timeout_n;
`endif
        end
    end
endmodule
